seq_tail_light: RTL
===================

# seq_tail_light

Parametrised sequential tail-light controller. It drives two banks of `N_LAMPS` lamps, left and right, in four modes: left turn sweep, right turn sweep, hazard breathing pattern, and brake steady-on. Animation speed comes from an internal clock prescaler. The block sits between the vehicle switch inputs and the lamp drivers, and it replaces the fixed 3-lamp, one-step-per-clock tail light.

## Interface
- `N_LAMPS`, default 3: lamps per side; must be ≥1.
- `TICK_DIV`, default 1: clock cycles per animation step; must be ≥1.
- `HOLD_STEPS`, default 0: extra steps a turn sweep holds fully lit before blanking; must be ≥0.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `lt`  in  1: left turn request.
- `rt`  in  1: right turn request.
- `haz`  in  1: hazard request.
- `brake`  in  1: brake pedal.
- `li`  out  N_LAMPS: left lamps. Bit N_LAMPS-1 is innermost and lights first.
- `ri`  out  N_LAMPS: right lamps. Bit 0 is innermost and lights first (mirror of `li`).

## Operation
- Requested mode, decoded each cycle:
  - HAZ if `haz`, or if `lt && rt`.
  - Otherwise LEFT if `lt`, RIGHT if `rt`, else OFF.
- State: registered mode `mode_q`, step counter `step`, prescaler `pcnt`.
- Tick: asserted when `pcnt == TICK_DIV-1`. On a tick `pcnt` wraps to 0; otherwise it increments.
- Mode change: if the requested mode differs from `mode_q` at an edge, then `mode_q` takes the new mode and both `step` and `pcnt` are set to 0. This has priority over a tick.
- Otherwise, on a tick, `step` advances and wraps per mode:
  - LEFT/RIGHT: steps 0…N_LAMPS+HOLD_STEPS, period N_LAMPS+HOLD_STEPS+1.
  - HAZ: steps 0…2·N_LAMPS-1.
  - OFF: `step` held at 0.
- Lit count `k` per step:
  - Turn: `k = min(step, N_LAMPS)`.
  - HAZ: `k = step` for step ≤ N_LAMPS, else `k = 2·N_LAMPS − step`.
- Side decode: a side showing `k` lights its `k` innermost lamps (thermometer code).
- Outputs per mode:
  - LEFT: `li` shows `k`. `ri` is all-ones if `brake`, else 0.
  - RIGHT: mirror of LEFT.
  - HAZ: both sides show `k`; `brake` is ignored.
  - OFF: both sides all-ones if `brake`, else 0.
- Counter widths:
  - `step`: `$clog2(max(N_LAMPS+HOLD_STEPS+1, 2·N_LAMPS))`, minimum 1.
  - `pcnt`: `$clog2(TICK_DIV)`, minimum 1.
  - No counter may exceed its terminal value.

## Timing
- Reset (`rst_n` low): `mode_q`=OFF, `step`=0, `pcnt`=0, `li`=0, `ri`=0, all applied immediately and asynchronously. Assertion in mid-sweep aborts the sweep.
- First cycle after reset release: outputs follow the inputs sampled at that edge.
- Outputs are registered. They are decoded from the state after edge n, using inputs sampled at edge n. Latency from an input change to an output change is 1 clock.
- Each animation step is visible for exactly TICK_DIV cycles. The exception is step 0 after a mode change, which also lasts TICK_DIV cycles because `pcnt` restarts at 0.
- `brake` has no effect on `step`. Toggling `brake` alone changes only the non-animating side(s), 1 cycle later.
- Holding the same mode restarts nothing. Only a change of requested mode resets `step`.
- HAZ with N_LAMPS=1: alternates 0 / 1 lamp lit, period 2 steps.

## Structure
- Package `tail_light_pkg`:
  - `typedef enum logic [1:0] {MODE_OFF, MODE_LEFT, MODE_RIGHT, MODE_HAZ} tl_mode_t`.
  - Function `therm(k, n)` returning an n-bit thermometer code.
- Sub-module `tick_prescaler` (parameter `TICK_DIV`; ports `clk`, `rst_n`, `clr`, `tick`):
  - `clr` is driven by the mode-change condition.
- Top level contains the mode register, step counter and output decode/registers.

## Test plan
All scenarios use N_LAMPS=3, TICK_DIV=2, HOLD_STEPS=1 unless stated.
1. Reset: drive `rst_n`=0 with `lt`=1 → `li`=`ri`=000 while low. Release with all inputs 0 → outputs stay 000.
2. Left turn: `lt`=1 held → `li` = 000,100,110,111,111, then repeats, each value 2 cycles (period 10 cycles); `ri`=000 throughout.
3. Hazard: `haz`=1 → `li`/`ri` = 000/000, 100/001, 110/011, 111/111, 110/011, 100/001, period 12 cycles. Repeat with `haz`=0, `lt`=`rt`=1 → identical pattern.
4. Brake:
   - `brake`=1 with `rt`=1 → `li`=111 constant; `ri` sweeps 000,001,011,111,111.
   - `brake`=1 alone → 111/111.
   - `brake`=1 under `haz` → pure hazard pattern.
5. Mode switch: while `li`=110, change `lt`→`rt` → next cycle `li`=000 and `ri`=000; `ri` reaches 001 after 2 cycles.
6. Mid-sweep reset and parameters:
   - Assert `rst_n` at `li`=111 → outputs 000 without waiting for a clock edge.
   - Re-run scenario 2 with TICK_DIV=1, HOLD_STEPS=0 → 000,100,110,111, one cycle each.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the sequential tail-light controller.
package tail_light_pkg;

  typedef enum logic [1:0] {MODE_OFF, MODE_LEFT, MODE_RIGHT, MODE_HAZ} tl_mode_t;

  localparam int TL_MAX_LAMPS = 32;

  // Low k bits set, clipped to n; callers map bit 0 to the innermost lamp.
  function automatic logic [TL_MAX_LAMPS-1:0] therm(input int k, input int n);
    logic [TL_MAX_LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < TL_MAX_LAMPS; i++) begin
      if (i < k && i < n) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Animation-step prescaler: tick every TICK_DIV cycles, restarted by clr.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_TERM = PCNT_W'(TICK_DIV - 1);

  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;

  assign tick = (pcnt_q == PCNT_TERM);

  always_comb begin
    pcnt_d = pcnt_q + PCNT_W'(1);
    if (clr || tick) pcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/seq_tail_light.sv
// Tail-light controller: turn sweeps, hazard breathing and brake, with
// registered lamp outputs decoded from the next state.
module seq_tail_light
  import tail_light_pkg::*;
#(
  parameter int N_LAMPS    = 3,
  parameter int TICK_DIV   = 1,
  parameter int HOLD_STEPS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lt,
  input  logic               rt,
  input  logic               haz,
  input  logic               brake,
  output logic [N_LAMPS-1:0] li,
  output logic [N_LAMPS-1:0] ri
);

  localparam int TURN_SPAN = N_LAMPS + HOLD_STEPS + 1;
  localparam int HAZ_SPAN  = 2 * N_LAMPS;
  localparam int STEP_SPAN = (TURN_SPAN > HAZ_SPAN) ? TURN_SPAN : HAZ_SPAN;
  localparam int STEP_W    = (STEP_SPAN > 2) ? $clog2(STEP_SPAN) : 1;
  localparam logic [STEP_W-1:0] TURN_TERM = STEP_W'(TURN_SPAN - 1);
  localparam logic [STEP_W-1:0] HAZ_TERM  = STEP_W'(HAZ_SPAN - 1);

  tl_mode_t            mode_q, mode_d, mode_req;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [N_LAMPS-1:0]  li_q, li_d, ri_q, ri_d;
  logic                mode_chg;
  logic                tick;
  int                  s;
  int                  k;
  logic [N_LAMPS-1:0]  side_ri, side_li, ones;

  always_comb begin
    mode_req = MODE_OFF;
    if (haz || (lt && rt)) mode_req = MODE_HAZ;
    else if (lt)           mode_req = MODE_LEFT;
    else if (rt)           mode_req = MODE_RIGHT;
  end

  assign mode_chg = (mode_req != mode_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mode_chg),
    .tick  (tick)
  );

  // A mode change restarts the animation and outranks a pending tick.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (mode_chg) begin
      mode_d = mode_req;
      step_d = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_LEFT, MODE_RIGHT: step_d = (step_q == TURN_TERM) ? '0 : step_q + STEP_W'(1);
        MODE_HAZ:              step_d = (step_q == HAZ_TERM)  ? '0 : step_q + STEP_W'(1);
        default:               step_d = '0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    s = int'(step_d);
    k = 0;
    case (mode_d)
      MODE_LEFT, MODE_RIGHT: k = (s < N_LAMPS) ? s : N_LAMPS;
      MODE_HAZ:              k = (s <= N_LAMPS) ? s : (2 * N_LAMPS - s);
      default:               k = 0;
    endcase
    side_ri = N_LAMPS'(therm(k, N_LAMPS));
    for (int i = 0; i < N_LAMPS; i++) side_li[i] = side_ri[N_LAMPS-1-i];
    ones = '1;
    li_d = brake ? ones : '0;
    ri_d = brake ? ones : '0;
    case (mode_d)
      MODE_LEFT:  li_d = side_li;
      MODE_RIGHT: ri_d = side_ri;
      MODE_HAZ: begin
        li_d = side_li;
        ri_d = side_ri;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      step_q <= '0;
      li_q   <= '0;
      ri_q   <= '0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      li_q   <= li_d;
      ri_q   <= ri_d;
    end
  end

  assign li = li_q;
  assign ri = ri_q;

endmodule
